// File: rtl/framebuffer_scanout.sv
// Raster timing generator and framebuffer reader with integer upscaling and double buffering.
// The address stage drives fbAddress from counters; the output stage aligns to the 1-cycle read.
module framebuffer_scanout #(
  parameter int unsigned FB_WIDTH   = 32,
  parameter int unsigned FB_HEIGHT  = 24,
  parameter int unsigned SCALE      = 20,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bufferSelect,
  output logic [ADDR_WIDTH-1:0] fbAddress,
  output logic                  fbReadEnable,
  input  logic [8:0]            fbData,
  output logic [2:0]            red,
  output logic [2:0]            green,
  output logic [2:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  dataEnable,
  output logic                  vblank,
  output logic                  frameStart
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FRONT;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FRONT;
  localparam int unsigned HImg       = FB_WIDTH * SCALE;
  localparam int unsigned VImg       = FB_HEIGHT * SCALE;
  localparam int unsigned HW         = $clog2(HTotal);
  localparam int unsigned VW         = $clog2(VTotal);
  localparam int unsigned XW         = $clog2(FB_WIDTH + 1);
  localparam int unsigned SW         = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [ADDR_WIDTH-1:0] FrameSize = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] RowStep   = ADDR_WIDTH'(FB_WIDTH);
  localparam logic [SW-1:0]         SubLast   = SW'(SCALE - 1);

  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [SW-1:0]         x_sub_q, x_sub_d, y_sub_q, y_sub_d;
  logic [XW-1:0]         fb_x_q, fb_x_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] frame_base_q, frame_base_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  hsync_q, vsync_q, de_q, vblank_q, frame_start_q, img_q;

  logic [31:0]           h_w, v_w;
  logic                  h_last, v_last, h_img, v_img, img;
  logic [ADDR_WIDTH-1:0] addr_calc;

  assign h_w    = 32'(h_cnt_q);
  assign v_w    = 32'(v_cnt_q);
  assign h_last = (h_w == HTotal - 1);
  assign v_last = (v_w == VTotal - 1);
  assign h_img  = (h_w < HImg);
  assign v_img  = (v_w < VImg);
  assign img    = h_img && v_img;

  assign addr_calc    = frame_base_q + row_base_q + ADDR_WIDTH'(fb_x_q);
  assign fbAddress    = img ? addr_calc : addr_hold_q;
  assign fbReadEnable = img;

  always_comb begin
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    x_sub_d      = x_sub_q;
    fb_x_d       = fb_x_q;
    y_sub_d      = y_sub_q;
    row_base_d   = row_base_q;
    frame_base_d = frame_base_q;
    addr_hold_d  = img ? addr_calc : addr_hold_q;

    // Horizontal sub-counter only runs across the image so fb_x stays bounded.
    if (h_last) begin
      h_cnt_d = '0;
      x_sub_d = '0;
      fb_x_d  = '0;
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
      if (h_img) begin
        if (x_sub_q == SubLast) begin
          x_sub_d = '0;
          fb_x_d  = fb_x_q + XW'(1);
        end else begin
          x_sub_d = x_sub_q + SW'(1);
        end
      end
    end

    if (h_last) begin
      if (v_last) begin
        v_cnt_d      = '0;
        y_sub_d      = '0;
        row_base_d   = '0;
        frame_base_d = bufferSelect ? FrameSize : '0;
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
        if (v_img) begin
          if (y_sub_q == SubLast) begin
            y_sub_d    = '0;
            row_base_d = row_base_q + RowStep;
          end else begin
            y_sub_d = y_sub_q + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_sub_q       <= '0;
      fb_x_q        <= '0;
      y_sub_q       <= '0;
      row_base_q    <= '0;
      frame_base_q  <= '0;
      addr_hold_q   <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      img_q         <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_sub_q       <= x_sub_d;
      fb_x_q        <= fb_x_d;
      y_sub_q       <= y_sub_d;
      row_base_q    <= row_base_d;
      frame_base_q  <= frame_base_d;
      addr_hold_q   <= addr_hold_d;
      hsync_q       <= !((h_w >= HSyncStart) && (h_w < HSyncStart + H_SYNC));
      vsync_q       <= !((v_w >= VSyncStart) && (v_w < VSyncStart + V_SYNC));
      de_q          <= (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
      vblank_q      <= (v_w >= V_ACTIVE);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      img_q         <= img;
    end
  end

  // fbData arrives one cycle after its address, so gate it with the delayed image flag.
  assign {red, green, blue} = img_q ? fbData : 9'd0;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign dataEnable = de_q;
  assign vblank     = vblank_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: a 4x2 image filling its active area and a 3x1 image with borders,
// both on the same 14x7 raster, checked against a cycle-index reference model.
module tb_framebuffer_scanout;

  typedef struct packed {
    int fw; int fh; int sc; int ha; int hf; int hs; int hb; int va; int vf; int vs; int vb;
  } cfg_t;

  typedef struct packed {
    bit img; int addr; bit hs; bit vs; bit de; bit vb; bit fs;
  } st_t;

  typedef struct {
    int k; int addr; bit re; bit hs; bit vs; bit de; bit vb; bit fs;
  } vec_t;

  localparam cfg_t CA = '{fw: 4, fh: 2, sc: 2, ha: 8, hf: 2, hs: 2, hb: 2,
                          va: 4, vf: 1, vs: 1, vb: 1};
  localparam cfg_t CB = '{fw: 3, fh: 1, sc: 2, ha: 8, hf: 2, hs: 2, hb: 2,
                          va: 4, vf: 1, vs: 1, vb: 1};
  localparam int Frame = 14 * 7;

  logic       clk, rst_n, bsel;
  logic [3:0] addr_a;
  logic [2:0] addr_b;
  logic       re_a, re_b;
  logic [8:0] fbd_a, fbd_b;
  logic [2:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       hs_a, vs_a, de_a, vb_a, fs_a, hs_b, vs_b, de_b, vb_b, fs_b;

  logic [15:0][8:0] mem_a, mem_b;

  int k, n_vec, n_err;
  bit sel_k, sel_km1;
  vec_t tab [19];

  framebuffer_scanout #(
    .FB_WIDTH(4), .FB_HEIGHT(2), .SCALE(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .ADDR_WIDTH(4)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .bufferSelect(bsel), .fbAddress(addr_a), .fbReadEnable(re_a),
    .fbData(fbd_a), .red(red_a), .green(green_a), .blue(blue_a), .hsync(hs_a), .vsync(vs_a),
    .dataEnable(de_a), .vblank(vb_a), .frameStart(fs_a)
  );

  framebuffer_scanout #(
    .FB_WIDTH(3), .FB_HEIGHT(1), .SCALE(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .ADDR_WIDTH(3)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .bufferSelect(bsel), .fbAddress(addr_b), .fbReadEnable(re_b),
    .fbData(fbd_b), .red(red_b), .green(green_b), .blue(blue_b), .hsync(hs_b), .vsync(vs_b),
    .dataEnable(de_b), .vblank(vb_b), .frameStart(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read framebuffer memories.
  always @(posedge clk) begin
    if (re_a) fbd_a <= mem_a[addr_a];
    if (re_b) fbd_b <= mem_b[{1'b0, addr_b}];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  // Expected address-stage state for cycle index k after reset (whole-raster arithmetic).
  function automatic st_t expect_at(input cfg_t c, input int kk, input bit sel);
    int ht, vt, h, v;
    st_t s;
    ht     = c.ha + c.hf + c.hs + c.hb;
    vt     = c.va + c.vf + c.vs + c.vb;
    h      = kk % ht;
    v      = (kk / ht) % vt;
    s.img  = (h < c.fw * c.sc) && (v < c.fh * c.sc);
    s.addr = (sel ? c.fw * c.fh : 0) + (v / c.sc) * c.fw + h / c.sc;
    s.hs   = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
    s.vs   = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
    s.de   = (h < c.ha) && (v < c.va);
    s.vb   = (v >= c.va);
    s.fs   = (h == 0) && (v == 0);
    return s;
  endfunction

  task automatic check_dut(input string tag, input cfg_t c, input int addr, input int re,
                           input int hs, input int vs, input int de, input int vb, input int fs,
                           input int rgb, input logic [15:0][8:0] mem);
    st_t cur, prv;
    int  exp_rgb;
    cur = expect_at(c, k, sel_k);
    chk({tag, "_readEnable"}, re, int'(cur.img));
    if (cur.img) chk({tag, "_fbAddress"}, addr, cur.addr);
    if (k == 0) begin
      chk({tag, "_rst_hsync"}, hs, 1);
      chk({tag, "_rst_vsync"}, vs, 1);
      chk({tag, "_rst_de"}, de, 0);
      chk({tag, "_rst_vblank"}, vb, 0);
      chk({tag, "_rst_frameStart"}, fs, 0);
      chk({tag, "_rst_rgb"}, rgb, 0);
    end else begin
      prv     = expect_at(c, k - 1, sel_km1);
      exp_rgb = prv.img ? int'(mem[4'(prv.addr)]) : 0;
      chk({tag, "_hsync"}, hs, int'(prv.hs));
      chk({tag, "_vsync"}, vs, int'(prv.vs));
      chk({tag, "_de"}, de, int'(prv.de));
      chk({tag, "_vblank"}, vb, int'(prv.vb));
      chk({tag, "_frameStart"}, fs, int'(prv.fs));
      chk({tag, "_rgb"}, rgb, exp_rgb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      k       = 0;
      sel_k   = 1'b0;
      sel_km1 = 1'b0;
    end else begin
      sel_km1 = sel_k;
      if (k % Frame == Frame - 1) sel_k = bsel;
      k++;
    end
    #1;
    check_dut("A", CA, int'(addr_a), int'(re_a), int'(hs_a), int'(vs_a), int'(de_a), int'(vb_a),
              int'(fs_a), int'({red_a, green_a, blue_a}), mem_a);
    check_dut("B", CB, int'(addr_b), int'(re_b), int'(hs_b), int'(vs_b), int'(de_b), int'(vb_b),
              int'(fs_b), int'({red_b, green_b, blue_b}), mem_b);
  endtask

  task automatic goto_k(input int kt);
    for (int n = 0; n < 1000 && k < kt; n++) step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    k     = 0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 9'($urandom);
      mem_b[i] = 9'($urandom);
    end
    mem_a[0] = 9'h1C5;

    // {k, addr, re, hsync, vsync, dataEnable, vblank, frameStart} for DUT A.
    tab[0]  = '{0,  0, 1, 1, 1, 0, 0, 0};
    tab[1]  = '{1,  0, 1, 1, 1, 1, 0, 1};
    tab[2]  = '{2,  1, 1, 1, 1, 1, 0, 0};
    tab[3]  = '{7,  3, 1, 1, 1, 1, 0, 0};
    tab[4]  = '{8,  0, 0, 1, 1, 1, 0, 0};
    tab[5]  = '{9,  0, 0, 1, 1, 0, 0, 0};
    tab[6]  = '{11, 0, 0, 0, 1, 0, 0, 0};
    tab[7]  = '{12, 0, 0, 0, 1, 0, 0, 0};
    tab[8]  = '{13, 0, 0, 1, 1, 0, 0, 0};
    tab[9]  = '{14, 0, 1, 1, 1, 0, 0, 0};
    tab[10] = '{15, 0, 1, 1, 1, 1, 0, 0};
    tab[11] = '{28, 4, 1, 1, 1, 0, 0, 0};
    tab[12] = '{35, 7, 1, 1, 1, 1, 0, 0};
    tab[13] = '{56, 0, 0, 1, 1, 0, 0, 0};
    tab[14] = '{57, 0, 0, 1, 1, 0, 1, 0};
    tab[15] = '{71, 0, 0, 1, 0, 0, 1, 0};
    tab[16] = '{85, 0, 0, 1, 1, 0, 1, 0};
    tab[17] = '{98, 8, 1, 1, 1, 0, 1, 0};
    tab[18] = '{99, 8, 1, 1, 1, 1, 0, 1};

    rst_n = 1'b0;
    bsel  = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // bufferSelect rises mid-frame; it must only take effect from the next frame.
    for (int i = 0; i < 19; i++) begin
      for (int n = 0; n < 200 && k < tab[i].k; n++) begin
        if (k == 20) bsel = 1'b1;
        step();
      end
      chk("tab_k", k, tab[i].k);
      chk("tab_re", int'(re_a), int'(tab[i].re));
      if (tab[i].re) chk("tab_addr", int'(addr_a), tab[i].addr);
      chk("tab_hsync", int'(hs_a), int'(tab[i].hs));
      chk("tab_vsync", int'(vs_a), int'(tab[i].vs));
      chk("tab_de", int'(de_a), int'(tab[i].de));
      chk("tab_vblank", int'(vb_a), int'(tab[i].vb));
      chk("tab_frameStart", int'(fs_a), int'(tab[i].fs));
      if (tab[i].k == 1) begin
        chk("pix_red", int'(red_a), 7);
        chk("pix_green", int'(green_a), 0);
        chk("pix_blue", int'(blue_a), 5);
      end
    end

    // Border checks on DUT B in frame 1 (base 3).
    chk("b_first_pix", int'({red_b, green_b, blue_b}), int'(mem_b[3]));
    goto_k(104);
    chk("b_border_re", int'(re_b), 0);
    goto_k(105);
    chk("b_border_de6", int'(de_b), 1);
    chk("b_border_rgb6", int'({red_b, green_b, blue_b}), 0);
    goto_k(106);
    chk("b_border_de7", int'(de_b), 1);
    chk("b_border_rgb7", int'({red_b, green_b, blue_b}), 0);
    goto_k(112);
    chk("b_line1_addr", int'(addr_b), 3);
    goto_k(126);
    chk("b_line2_re", int'(re_b), 0);
    goto_k(127);
    chk("b_line2_de", int'(de_b), 1);
    chk("b_line2_rgb", int'({red_b, green_b, blue_b}), 0);

    // One-cycle reset in the middle of a line.
    goto_k(201);
    rst_n = 1'b0;
    step();
    chk("mid_rst_hsync", int'(hs_a), 1);
    chk("mid_rst_de", int'(de_a), 0);
    chk("mid_rst_fs", int'(fs_a), 0);
    chk("mid_rst_addr", int'(addr_a), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_fs", int'(fs_a), 1);
    chk("post_rst_de", int'(de_a), 1);
    chk("post_rst_addr", int'(addr_a), 0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 29) == 0) bsel = ~bsel;
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
